// File: rtl/t08_spi_pkg.sv
// Shared types and constants for the display-side SPI transmitter.
package t08_spi_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SHIFT      = 2'd1,
    WAIT_PARAM = 2'd2,
    END        = 2'd3
  } state_t;

  localparam int   BYTES_PER_WORD = 4;
  localparam logic CMD_DC         = 1'b0;
  localparam logic PARAM_DC       = 1'b1;

endpackage

// File: rtl/t08_spi_clkgen.sv
// SCLK generator: CLK_DIV clocks per half-period, one-cycle rise/fall enables.
// Held idle (sclk low, count cleared) whenever enable is low.
module t08_spi_clkgen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic sclk,
  output logic sclk_rise,
  output logic sclk_fall
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic          phase_end;

  assign phase_end = enable && (div_cnt == LAST);
  assign sclk_rise = phase_end && !sclk;
  assign sclk_fall = phase_end && sclk;

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (phase_end) begin
      div_cnt <= '0;
      sclk    <= ~sclk;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

endmodule

// File: rtl/t08_spi_tx.sv
// Display SPI transmitter: one command byte (dc=0) then 0-15 parameter bytes (dc=1), mode 0.
// Each byte takes 16*CLK_DIV clocks; writes arriving while busy, or out of sequence, are dropped.
module t08_spi_tx
  import t08_spi_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_write_i,
  input  logic [7:0]  command_i,
  input  logic [3:0]  counter_i,
  input  logic        param_write_i,
  input  logic [31:0] parameters_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        sclk_o,
  output logic        mosi_o,
  output logic        cs_n_o,
  output logic        dc_o
);

  state_t      state, state_n;
  logic [31:0] shift_reg;
  logic [3:0]  remaining;
  logic [2:0]  bytes_left;
  logic [2:0]  bit_cnt;
  logic [2:0]  take;
  logic        sclk_rise, sclk_fall;
  logic        accept_cmd, accept_param, byte_end, word_end;

  t08_spi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk       (clk),
    .rst       (rst),
    .enable    (state == SHIFT),
    .sclk      (sclk_o),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall)
  );

  // A command always wins over a simultaneous parameter word.
  assign accept_cmd   = cmd_write_i && (state == IDLE || state == WAIT_PARAM);
  assign accept_param = param_write_i && !cmd_write_i && (state == WAIT_PARAM);
  // bit_cnt counts rises, so it has wrapped to 0 by the eighth fall.
  assign byte_end     = (state == SHIFT) && sclk_fall && (bit_cnt == 3'd0);
  assign word_end     = byte_end && (bytes_left == 3'd1);
  assign take         = (remaining >= 4'(BYTES_PER_WORD)) ? 3'(BYTES_PER_WORD) : remaining[2:0];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    cs_n_o  = 1'b1;
    case (state)
      IDLE: begin
        if (accept_cmd) state_n = SHIFT;
      end
      SHIFT: begin
        busy_o = 1'b1;
        cs_n_o = 1'b0;
        if (word_end) state_n = (remaining != 4'd0) ? WAIT_PARAM : END;
      end
      WAIT_PARAM: begin
        cs_n_o = 1'b0;
        if (accept_cmd || accept_param) state_n = SHIFT;
      end
      END: begin
        done_o  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg  <= '0;
      remaining  <= '0;
      bytes_left <= '0;
      bit_cnt    <= '0;
      mosi_o     <= 1'b0;
      dc_o       <= 1'b1;
    end else if (accept_cmd) begin
      shift_reg  <= {command_i, 24'h0};
      remaining  <= counter_i;
      bytes_left <= 3'd1;
      bit_cnt    <= '0;
      mosi_o     <= command_i[7];
      dc_o       <= CMD_DC;
    end else if (accept_param) begin
      shift_reg  <= parameters_i;
      remaining  <= remaining - 4'(take);
      bytes_left <= take;
      bit_cnt    <= '0;
      mosi_o     <= parameters_i[31];
      dc_o       <= PARAM_DC;
    end else if (state == SHIFT) begin
      if (sclk_rise) bit_cnt <= bit_cnt + 3'd1;
      if (sclk_fall) begin
        // Shifting the whole word leaves the next byte's MSB on top with no gap.
        shift_reg <= {shift_reg[30:0], 1'b0};
        mosi_o    <= word_end ? 1'b0 : shift_reg[30];
        if (byte_end) bytes_left <= bytes_left - 3'd1;
      end
    end
  end

endmodule
